// File: rtl/innings_controller.sv
// innings_controller: turns bowl presses into delivery pulses with outcome codes, tracks balls/overs/wickets per innings and decides the match.
// Ports:
//   clk_fpga, reset    - system clock, asynchronous active-high reset
//   bowl_btn           - debounced, synchronised bowl button level
//   test_mode          - 1 selects test_outcome instead of the LFSR as the outcome source
//   test_outcome       - forced outcome code
//   team1Data/2Data    - accumulator records, runs [11:4], wickets [3:0]
//   delivery           - one-cycle pulse per bowled ball
//   lfsr_out           - outcome code of the latest delivery
//   teamSwitch         - 0 while team 1 bats, 1 while team 2 bats
//   gameOver, winner   - match finished flag and result (01 team1, 10 team2, 11 tie)
//   overs, balls       - completed overs and legal balls of the current over
//   inn_wickets        - wickets fallen in the current innings
module innings_controller #(
  parameter int MAX_OVERS = 2,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        bowl_btn,
  input  logic        test_mode,
  input  logic [3:0]  test_outcome,
  input  logic [11:0] team1Data,
  input  logic [11:0] team2Data,
  output logic        delivery,
  output logic [3:0]  lfsr_out,
  output logic        teamSwitch,
  output logic        gameOver,
  output logic [3:0]  overs,
  output logic [2:0]  balls,
  output logic [3:0]  inn_wickets,
  output logic [1:0]  winner
);
  typedef enum logic [1:0] {INN1, BRK, INN2, DONE} state_t;
  state_t state;
  logic [3:0] q;
  logic btn_q, fire;
  logic press, inn_end, chase, legal, wicket;
  logic [3:0] outcome;
  logic [7:0] runs1, runs2;
  logic unused_wickets;
  assign runs1 = team1Data[11:4];
  assign runs2 = team2Data[11:4];
  assign unused_wickets = ^{team1Data[3:0], team2Data[3:0]};
  assign press = bowl_btn & ~btn_q;
  assign inn_end = (overs == 4'(MAX_OVERS)) || (inn_wickets == 4'd10);
  // Runs land in the accumulator a cycle after the delivery, so this is checked every cycle
  assign chase = (state == INN2) && (runs2 > runs1);
  assign outcome = test_mode ? test_outcome : q;
  assign legal = (outcome != 4'd13) && (outcome != 4'd14);
  assign wicket = outcome == 4'd15;
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state       <= INN1;
      q           <= LFSR_SEED;
      btn_q       <= 1'b0;
      fire        <= 1'b0;
      delivery    <= 1'b0;
      lfsr_out    <= 4'd0;
      teamSwitch  <= 1'b0;
      gameOver    <= 1'b0;
      overs       <= 4'd0;
      balls       <= 3'd0;
      inn_wickets <= 4'd0;
      winner      <= 2'b00;
    end else begin
      q        <= {q[2:0], q[3] ^ q[2]};
      btn_q    <= bowl_btn;
      delivery <= 1'b0;
      fire     <= 1'b0;
      case (state)
        INN1, INN2: begin
          if (chase) begin
            state    <= DONE;
            gameOver <= 1'b1;
            winner   <= 2'b10;
          end else if (inn_end) begin
            // Innings over: presses are ignored until this transition
            if (state == INN1) state <= BRK;
            else begin
              state    <= DONE;
              gameOver <= 1'b1;
              winner   <= (runs1 > runs2) ? 2'b01 : (runs2 > runs1) ? 2'b10 : 2'b11;
            end
          end else if (fire) begin
            delivery    <= 1'b1;
            lfsr_out    <= outcome;
            balls       <= !legal ? balls : (balls == 3'd5) ? 3'd0 : balls + 3'd1;
            overs       <= (legal && balls == 3'd5) ? overs + 4'd1 : overs;
            inn_wickets <= wicket ? inn_wickets + 4'd1 : inn_wickets;
          end else begin
            fire <= press;
          end
        end
        BRK: begin
          if (press) begin
            state       <= INN2;
            teamSwitch  <= 1'b1;
            overs       <= 4'd0;
            balls       <= 3'd0;
            inn_wickets <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_innings_controller.sv
// tb_innings_controller: directed, table-driven checks of innings_controller.
module tb_innings_controller;
  logic        clk_fpga = 1'b0;
  logic        reset = 1'b1;
  logic        bowl_btn = 1'b0;
  logic        test_mode = 1'b1;
  logic [3:0]  test_outcome = 4'd0;
  logic [11:0] team1Data = 12'd0;
  logic [11:0] team2Data = 12'd0;
  logic        delivery, teamSwitch, gameOver;
  logic [3:0]  lfsr_out, overs, inn_wickets;
  logic [2:0]  balls;
  logic [1:0]  winner;
  innings_controller dut (
    .clk_fpga(clk_fpga), .reset(reset), .bowl_btn(bowl_btn), .test_mode(test_mode),
    .test_outcome(test_outcome), .team1Data(team1Data), .team2Data(team2Data),
    .delivery(delivery), .lfsr_out(lfsr_out), .teamSwitch(teamSwitch), .gameOver(gameOver),
    .overs(overs), .balls(balls), .inn_wickets(inn_wickets), .winner(winner)
  );
  always #5 clk_fpga = ~clk_fpga;
  int errors = 0;
  int checks = 0;
  int dcount = 0;
  logic [3:0] m_q;
  always @(posedge clk_fpga or posedge reset)
    m_q <= reset ? 4'b1001 : {m_q[2:0], m_q[3] ^ m_q[2]};
  always @(negedge clk_fpga) if (delivery) dcount++;
  typedef struct {int o; int b; int ov; int wk;} vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_fpga);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bowl_btn = 1'b0;
    tick;
    #2 reset = 1'b0;
    tick;
  endtask
  task automatic press(input int o, output logic seen);
    test_outcome = 4'(o);
    bowl_btn = 1'b1;
    tick;
    tick;
    seen = delivery;
    bowl_btn = 1'b0;
    tick;
    tick;
  endtask
  task automatic chk_cnt(input string tag, input int b, input int ov, input int wk);
    chk({tag, " balls"}, int'(balls), b);
    chk({tag, " overs"}, int'(overs), ov);
    chk({tag, " wickets"}, int'(inn_wickets), wk);
  endtask
  initial begin
    logic seen;
    int base;
    logic [3:0] exp_q;
    vecs = '{'{13, 0, 0, 0}, '{13, 0, 0, 0}, '{14, 0, 0, 0}, '{3, 1, 0, 0}, '{15, 2, 0, 1},
             '{4, 3, 0, 1}, '{4, 4, 0, 1}, '{4, 5, 0, 1}, '{0, 0, 1, 1}, '{12, 1, 1, 1},
             '{15, 2, 1, 2}};
    #2;
    chk("rst delivery", int'(delivery), 0);
    chk("rst lfsr_out", int'(lfsr_out), 0);
    chk("rst teamSwitch", int'(teamSwitch), 0);
    chk("rst gameOver", int'(gameOver), 0);
    chk("rst winner", int'(winner), 0);
    chk_cnt("rst", 0, 0, 0);
    reset = 1'b0;
    tick;
    foreach (vecs[i]) begin
      press(vecs[i].o, seen);
      chk($sformatf("vec%0d delivery", i), int'(seen), 1);
      chk($sformatf("vec%0d lfsr_out", i), int'(lfsr_out), vecs[i].o);
      chk_cnt($sformatf("vec%0d", i), vecs[i].b, vecs[i].ov, vecs[i].wk);
    end
    do_reset;
    base = dcount;
    for (int i = 1; i <= 12; i++) begin
      press(4, seen);
      if (i == 6) chk_cnt("overs6", 0, 1, 0);
      if (i == 11) chk_cnt("overs11", 5, 1, 0);
    end
    chk_cnt("inn1 end", 0, 2, 0);
    chk("12 pulses", dcount - base, 12);
    chk("brk teamSwitch", int'(teamSwitch), 0);
    press(4, seen);
    chk("brk no delivery", int'(seen), 0);
    chk("brk pulses", dcount - base, 12);
    chk("inn2 teamSwitch", int'(teamSwitch), 1);
    chk_cnt("inn2 start", 0, 0, 0);
    team1Data = {8'd20, 4'd0};
    team2Data = {8'd20, 4'd0};
    for (int i = 0; i < 12; i++) press(4, seen);
    chk("tie gameOver", int'(gameOver), 1);
    chk("tie winner", int'(winner), 3);
    press(4, seen);
    chk("done no delivery", int'(seen), 0);
    chk_cnt("done frozen", 0, 2, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst done gameOver", int'(gameOver), 0);
    chk("rst done winner", int'(winner), 0);
    chk("rst done teamSwitch", int'(teamSwitch), 0);
    chk_cnt("rst done", 0, 0, 0);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) press(15, seen);
    chk_cnt("10 wickets", 4, 1, 10);
    base = dcount;
    press(4, seen);
    chk("wk brk no delivery", int'(seen), 0);
    chk("wk brk pulses", dcount - base, 0);
    chk("wk inn2 teamSwitch", int'(teamSwitch), 1);
    chk_cnt("wk inn2", 0, 0, 0);
    press(4, seen);
    chk("inn2 delivery", int'(seen), 1);
    chk_cnt("inn2 ball", 1, 0, 0);
    team2Data = {8'd21, 4'd1};
    chk("pre chase gameOver", int'(gameOver), 0);
    tick;
    chk("chase gameOver", int'(gameOver), 1);
    chk("chase winner", int'(winner), 2);
    press(4, seen);
    chk("chase no delivery", int'(seen), 0);
    chk_cnt("chase frozen", 1, 0, 0);
    do_reset;
    test_mode = 1'b0;
    base = dcount;
    bowl_btn = 1'b1;
    tick;
    exp_q = m_q;
    repeat (49) tick;
    chk("held pulses", dcount - base, 1);
    chk("lfsr first", int'(lfsr_out), int'(exp_q));
    bowl_btn = 1'b0;
    tick;
    test_mode = 1'b1;
    do_reset;
    test_outcome = 4'd15;
    bowl_btn = 1'b1;
    tick;
    tick;
    chk("mid delivery", int'(delivery), 1);
    chk("mid wickets", int'(inn_wickets), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid rst delivery", int'(delivery), 0);
    chk("mid rst wickets", int'(inn_wickets), 0);
    chk("mid rst balls", int'(balls), 0);
    reset = 1'b0;
    bowl_btn = 1'b0;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/innings_controller.md
Name: innings_controller

Overview:
- Drives the delivery interface consumed by the score/wicket accumulator.
- Turns debounced "bowl" presses into single-cycle delivery pulses, each with a registered 4-bit outcome code taken from an internal LFSR.
- Counts legal balls, overs and wickets per innings, and switches batting team after innings 1.
- Ends the match on overs exhausted, 10 wickets, or a successful chase, then declares the winner from the accumulator's team data.

Parameters:
- MAX_OVERS, 2, overs per innings (1..15).
- LFSR_SEED, 4'b1001, nonzero LFSR reset value.

Ports:
- clk_fpga input 1: system clock.
- reset input 1: asynchronous, active-high reset.
- bowl_btn input 1: debounced, synchronised bowl button (level).
- test_mode input 1: 1 = outcome comes from test_outcome instead of the LFSR.
- test_outcome input 4: forced outcome code.
- team1Data input 12: accumulator team 1 record, runs [11:4], wickets [3:0].
- team2Data input 12: accumulator team 2 record, same packing.
- delivery output 1: one-cycle pulse per bowled ball.
- lfsr_out output 4: outcome code, valid with delivery, held until the next delivery.
- teamSwitch output 1: 0 = team 1 batting, 1 = team 2 batting.
- gameOver output 1: match finished.
- overs output 4: completed overs, current innings.
- balls output 3: legal balls in current over (0..5).
- inn_wickets output 4: wickets, current innings.
- winner output 2: 00 = undecided, 01 = team 1, 10 = team 2, 11 = tie.

Behaviour:
- Reset (async): state=INN1; all outputs 0; LFSR=LFSR_SEED; button-edge register=0.
- LFSR free-runs every cycle: next = {q[2:0], q[3]^q[2]}, period 15, never 0.
- Press detection: rising edge of bowl_btn, using a registered previous value. Level-held presses produce a single event.
- State INN1 / INN2, on a press edge sampled at edge N:
  - At edge N+1: delivery=1 for exactly one cycle.
  - lfsr_out <= (test_mode ? test_outcome : LFSR q) as sampled at edge N+1.
  - Counters update at the same edge N+1.
- Outcome classes:
  - 0..12: legal ball; balls+1.
  - 13, 14: extra (wide/no-ball); no ball counted.
  - 15: legal ball and wicket; balls+1, inn_wickets+1.
  - When balls would reach 6: balls<=0, overs+1.
- Innings end: after the update, overs==MAX_OVERS or inn_wickets==10.
  - The state changes at the next edge (N+2).
  - Further presses from edge N+1 onward are ignored until the state changes.
- INN1 end -> BRK: teamSwitch stays 0.
- BRK: next press edge moves to INN2. No delivery is produced. At that edge teamSwitch<=1 and overs, balls, inn_wickets <= 0.
- INN2 chase check: every cycle, if team2Data[11:4] > team1Data[11:4], go to DONE at the next edge. This check has priority over the overs/wickets end. It accounts for the accumulator updating one cycle after delivery.
- INN2 end (overs/wickets) -> DONE.
- DONE:
  - gameOver<=1; winner<=01/10/11 by comparing runs fields (team1 > team2 / team2 > team1 / equal).
  - All presses ignored; outputs frozen until reset.
  - delivery never asserts in BRK or DONE.
- Arithmetic: all counters unsigned, no wrap possible within limits. lfsr_out holds its value across innings.
- Reset mid-delivery: the pulse is cancelled immediately; state returns to INN1.

Test Plan:
- test_mode=1, outcome=4, 12 presses with MAX_OVERS=2 -> 12 delivery pulses, each 1 cycle. Overs steps 0->1->2 at balls 6/12. BRK entered 1 cycle after the 12th pulse; teamSwitch=0.
- test_mode=1, outcome=13 x3 then outcome=3 -> balls stays 0 through the extras, then reads 1. overs=0.
- test_mode=1, outcome=15 x10 in INN1 -> inn_wickets=10. BRK after the 10th pulse with overs=1, balls=4. The 11th press produces no delivery and moves to INN2 with teamSwitch=1 and counters cleared.
- In INN2, drive team1Data runs=20, team2Data runs 20 -> 21 -> DONE one cycle after the change; gameOver=1, winner=10. With runs held at 20, running out of overs gives winner=11.
- bowl_btn held high for 50 cycles -> exactly one delivery pulse. test_mode=0 from reset -> first lfsr_out equals the LFSR state one edge after the press.
- Assert reset during the delivery cycle and in DONE -> delivery, gameOver, counters and teamSwitch all 0 immediately (asynchronously); state INN1.
